uart_mem_arbiter: RTL and testbench
===================================

// Module: uart_mem_arbiter
// PURPOSE
//  Shares one byte-wide UART (TX/RX FIFO interface) between two memory requesters:
//  port 0 = instruction fetch, port 1 = data memory. Each request becomes a byte packet
//  to the host-side memory model; read replies are collected from RX. Sits between the
//  CPU memory stages and the uart block. Round-robin arbitration, one transaction at a time.
// PARAMETERS
//  addr_bytes  4  address bytes per packet; address width = 8*addr_bytes
//  data_bytes  4  data bytes per packet; data width = 8*data_bytes
// PORTS
//  clk          in   1     clock
//  rst          in   1     reset, asynchronous, active-high
//  req0/req1    in   1     request from port 0/1; held until doneN
//  we0/we1      in   1     1 = write, 0 = read
//  addr0/addr1  in   AW    byte address (AW = 8*addr_bytes)
//  wdata0/1     in   DW    write data (DW = 8*data_bytes)
//  rdata0/1     out  DW    read data; valid with doneN, held until next read on that port
//  done0/done1  out  1     one-cycle completion pulse
//  busy         out  1     transaction in progress (state != IDLE)
//  send_flag    out  1     push send_data into TX FIFO this cycle
//  send_data    out  8     byte to transmit
//  send_able    in   1     TX FIFO not full
//  recv_flag    out  1     pop RX FIFO this cycle
//  recv_data    in   8     RX FIFO head; valid whenever recv_able=1
//  recv_able    in   1     RX FIFO not empty
// BEHAVIOUR
//  Reset: all outputs 0 (rdata0/1, done0/1, busy, send_flag, send_data, recv_flag);
//   state IDLE, last_grant = 1 (port 0 wins first); packet in flight is abandoned.
//  Packet: header {we, 6'b0, port_id}, addr LSB first, then (write) data LSB first.
//   Read: after header+addr, receive data_bytes bytes LSB first into rdata.
//  FSM: IDLE -> SEND_HDR -> SEND_ADDR -> (we ? SEND_DATA : RECV_DATA) -> DONE -> IDLE.
//   IDLE: if any req, grant; latch we/addr/wdata/port into internal regs; -> SEND_HDR.
//    Both req: grant port != last_grant; last_grant updated on grant.
//    No req and recv_able: pop and discard stray RX byte (recv_flag=1).
//   SEND_*: send_flag = send_able (combinational); byte counter advances only on push;
//    send_data = current byte whenever in SEND_* state, else 0.
//   RECV_DATA: recv_flag = recv_able (combinational); byte stored at counter position.
//   DONE: doneN=1 for granted port one cycle (registered); rdataN updated for reads only.
//  Latency (send_able/recv_able always 1, default params): req seen in IDLE at cycle 0,
//   9 byte cycles 1..9, doneN in cycle 10, IDLE in cycle 11 (accepts next req there).
//  send_able=0 / recv_able=0: stall in place; no byte skipped, duplicated or reordered.
//  req dropped after grant: transaction still completes, done still pulsed.
//  Request fields read only in the grant cycle; later changes ignored.
//  Never asserts send_flag and recv_flag in the same cycle; never both done pulses.
//  No timeout: missing RX bytes stall RECV_DATA indefinitely (reset recovers).
// TESTING
//  1 port0 write addr 0x00001000 data 0xDEADBEEF, send_able=1 -> bytes 80,00,10,00,00,
//    EF,BE,AD,DE on consecutive cycles 1..9; done0 at cycle 10; done1 never.
//  2 port1 read addr 0x4, RX supplies 78,56,34,12 -> bytes 01,04,00,00,00 sent;
//    rdata1=0x12345678 with done1; rdata0 unchanged.
//  3 req0 and req1 held continuously -> grants 0,1,0,1 (header bit0 alternates);
//    each doneN pulse one cycle.
//  4 send_able=0 for 3 cycles after 2nd addr byte -> send_flag low those cycles;
//    full byte sequence identical to scenario 1, done0 delayed by 3 cycles.
//  5 stray RX byte 0xAA while idle, then port1 read -> 0xAA popped and dropped;
//    rdata1 built only from post-header bytes.
//  6 rst asserted mid RECV_DATA -> all outputs 0 immediately; next req0 read starts
//    with header byte 00, done0 after full packet.

Source files
------------

// File: rtl/uart_mem_arbiter_if.sv
// Bundle of signals between the arbiter, its two memory requesters and the UART FIFOs.
//   slave  : arbiter view (takes requests and UART status, drives results and FIFO strobes)
//   master : environment view (requesters plus UART FIFO model)
// Signals:
//   req0/1, we0/1, addr0/1, wdata0/1  request side, per port
//   rdata0/1, done0/1, busy           completion side, per port
//   send_flag/send_data/send_able     TX FIFO push interface
//   recv_flag/recv_data/recv_able     RX FIFO pop interface
interface uart_mem_arbiter_if #(
  parameter int unsigned addr_bytes = 4,
  parameter int unsigned data_bytes = 4
);
  logic                      req0, req1;
  logic                      we0, we1;
  logic [8*addr_bytes-1:0]   addr0, addr1;
  logic [8*data_bytes-1:0]   wdata0, wdata1;
  logic [8*data_bytes-1:0]   rdata0, rdata1;
  logic                      done0, done1;
  logic                      busy;
  logic                      send_flag;
  logic [7:0]                send_data;
  logic                      send_able;
  logic                      recv_flag;
  logic [7:0]                recv_data;
  logic                      recv_able;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output rdata0, rdata1, done0, done1, busy,
    output send_flag, send_data,
    input  send_able,
    output recv_flag,
    input  recv_data, recv_able
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  rdata0, rdata1, done0, done1, busy,
    input  send_flag, send_data,
    output send_able,
    input  recv_flag,
    output recv_data, recv_able
  );
endinterface

// File: rtl/uart_mem_arbiter.sv
// Shares one byte-wide UART between two memory requesters (0 = fetch, 1 = data).
// Each granted request is serialised as {we,6'b0,port}, address LSB first, then write data
// LSB first; reads then collect data_bytes reply bytes from RX, LSB first.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : uart_mem_arbiter_if.slave (requests, results, TX/RX FIFO strobes)
module uart_mem_arbiter #(
  parameter int unsigned addr_bytes = 4,
  parameter int unsigned data_bytes = 4
) (
  input logic               clk,
  input logic               rst,
  uart_mem_arbiter_if.slave bus
);
  localparam int unsigned AW = 8 * addr_bytes;
  localparam int unsigned DW = 8 * data_bytes;

  typedef enum logic [2:0] {
    StIdle, StSendHdr, StSendAddr, StSendData, StRecvData, StDone
  } state_e;

  state_e        state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic          port_q, port_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  // Holds write data, or the read reply while it is being assembled.
  logic [DW-1:0] data_q, data_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic          done0_q, done0_d, done1_q, done1_d;

  logic          send_flag, recv_flag, grant;
  logic [7:0]    send_data;
  logic [DW-1:0] rx_word;
  logic          last_addr, last_data;

  assign last_addr = (cnt_q == 8'(addr_bytes - 1));
  assign last_data = (cnt_q == 8'(data_bytes - 1));

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    port_d       = port_q;
    we_d         = we_q;
    addr_d       = addr_q;
    data_d       = data_q;
    cnt_d        = cnt_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    done0_d      = 1'b0;
    done1_d      = 1'b0;
    send_flag    = 1'b0;
    recv_flag    = 1'b0;
    send_data    = 8'h00;
    grant        = 1'b0;
    rx_word      = data_q;
    rx_word[8*cnt_q +: 8] = bus.recv_data;

    unique case (state_q)
      StIdle: begin
        if (bus.req0 || bus.req1) begin
          // Contention goes to the port that did not win last time.
          grant        = (bus.req0 && bus.req1) ? ~last_grant_q : bus.req1;
          last_grant_d = grant;
          port_d       = grant;
          we_d         = grant ? bus.we1 : bus.we0;
          addr_d       = grant ? bus.addr1 : bus.addr0;
          data_d       = grant ? bus.wdata1 : bus.wdata0;
          cnt_d        = 8'd0;
          state_d      = StSendHdr;
        end else if (bus.recv_able) begin
          recv_flag = 1'b1;  // stray RX byte, dropped
        end
      end
      StSendHdr: begin
        send_data = {we_q, 6'b0, port_q};
        send_flag = bus.send_able;
        if (bus.send_able) state_d = StSendAddr;
      end
      StSendAddr: begin
        send_data = addr_q[8*cnt_q +: 8];
        send_flag = bus.send_able;
        if (bus.send_able) begin
          if (last_addr) begin
            cnt_d   = 8'd0;
            state_d = we_q ? StSendData : StRecvData;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      StSendData: begin
        send_data = data_q[8*cnt_q +: 8];
        send_flag = bus.send_able;
        if (bus.send_able) begin
          if (last_data) begin
            state_d = StDone;
            done0_d = ~port_q;
            done1_d = port_q;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      StRecvData: begin
        recv_flag = bus.recv_able;
        if (bus.recv_able) begin
          data_d = rx_word;
          if (last_data) begin
            state_d = StDone;
            done0_d = ~port_q;
            done1_d = port_q;
            // Publish together with the done pulse.
            if (port_q) rdata1_d = rx_word;
            else        rdata0_d = rx_word;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      port_q       <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      cnt_q        <= 8'd0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      port_q       <= port_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      cnt_q        <= cnt_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
    end
  end

  // FIFO strobes are held low while reset is asserted so nothing is pushed or popped.
  assign bus.send_flag = send_flag & ~rst;
  assign bus.recv_flag = recv_flag & ~rst;
  assign bus.send_data = send_data;
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;
  assign bus.done0     = done0_q;
  assign bus.done1     = done1_q;
  assign bus.busy      = (state_q != StIdle);
endmodule

// File: tb/tb_uart_mem_arbiter.sv
module tb_uart_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_mem_arbiter_if #(.addr_bytes(4), .data_bytes(4)) bus ();

  uart_mem_arbiter #(.addr_bytes(4), .data_bytes(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic        p;
    logic        w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] reply;
    int          st_from;
    int          st_len;
    int          stall_pct;
    bit          drop;
    logic [7:0]  exp_hdr;
    int          exp_lat;
  } vec_t;

  int n_chk = 0;
  int n_pass = 0;
  int conflicts = 0;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] popped_q[$];
  bit rx_en = 1'b1;
  logic d0, d1, prev_d0, prev_d1, popping;
  logic [31:0] model_rd[2];

  task automatic check(input string nm, input logic [79:0] got, input logic [79:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  // One clock cycle: present RX head, sample outputs mid-cycle, commit FIFO effects at the edge.
  task automatic tick();
    bus.recv_able = rx_en && (rx_q.size() > 0);
    bus.recv_data = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
    #2;
    if (bus.send_flag) tx_q.push_back(bus.send_data);
    popping = bus.recv_flag;
    if (popping) popped_q.push_back(bus.recv_data);
    d0 = bus.done0;
    d1 = bus.done1;
    if (bus.send_flag && bus.recv_flag) conflicts++;
    if (d0 && d1) conflicts++;
    if ((d0 && prev_d0) || (d1 && prev_d1)) conflicts++;
    prev_d0 = d0;
    prev_d1 = d1;
    @(posedge clk);
    if (popping && rx_q.size() > 0) void'(rx_q.pop_front());
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    @(negedge clk);
    rst = 1'b0;
    model_rd[0] = '0;
    model_rd[1] = '0;
  endtask

  // Drives one request and checks it against a packet-level model of the protocol.
  task automatic run_txn(input vec_t v, input string nm);
    logic [7:0] exp_q[$];
    int lat, dn, other, bad;
    exp_q.push_back({v.w, 6'b0, v.p});
    for (int i = 0; i < 4; i++) exp_q.push_back(v.addr[8*i +: 8]);
    if (v.w) for (int i = 0; i < 4; i++) exp_q.push_back(v.wdata[8*i +: 8]);
    tx_q.delete();
    rx_q.delete();
    if (!v.w) for (int i = 0; i < 4; i++) rx_q.push_back(v.reply[8*i +: 8]);
    if (v.p) begin
      bus.req1 = 1'b1; bus.we1 = v.w; bus.addr1 = v.addr; bus.wdata1 = v.wdata;
    end else begin
      bus.req0 = 1'b1; bus.we0 = v.w; bus.addr0 = v.addr; bus.wdata0 = v.wdata;
    end
    lat = -1; dn = 0; other = 0;
    for (int c = 0; c < 300; c++) begin
      bus.send_able = !(c >= v.st_from && c < v.st_from + v.st_len) &&
                      (v.stall_pct == 0 || $urandom_range(99) >= v.stall_pct);
      rx_en = !(c >= v.st_from && c < v.st_from + v.st_len) &&
              (v.stall_pct == 0 || $urandom_range(99) >= v.stall_pct);
      if (c == 1) begin
        // Fields must have been captured at grant; scramble them now.
        if (v.p) begin bus.we1 = $urandom; bus.addr1 = $urandom; bus.wdata1 = $urandom; end
        else     begin bus.we0 = $urandom; bus.addr0 = $urandom; bus.wdata0 = $urandom; end
        if (v.drop) begin
          if (v.p) bus.req1 = 1'b0; else bus.req0 = 1'b0;
        end
      end
      tick();
      if (v.p ? d1 : d0) begin
        dn++;
        if (lat < 0) lat = c;
        if (v.p) bus.req1 = 1'b0; else bus.req0 = 1'b0;
      end
      if (v.p ? d0 : d1) other++;
      if (lat >= 0 && c == lat + 1) break;
    end
    bus.send_able = 1'b1;
    rx_en = 1'b1;
    if (lat < 0) $display("FAIL %s timeout: no done within budget", nm);
    check({nm, " done count"}, 80'(dn), 80'd1);
    check({nm, " other done"}, 80'(other), 80'd0);
    if (v.exp_lat >= 0) check({nm, " latency"}, 80'(lat), 80'(v.exp_lat));
    check({nm, " header"}, (tx_q.size() > 0) ? 80'(tx_q[0]) : 80'hx, 80'(v.exp_hdr));
    bad = (tx_q.size() == exp_q.size()) ? -1 : 999;
    for (int i = 0; i < exp_q.size() && i < tx_q.size(); i++)
      if (bad == -1 && tx_q[i] !== exp_q[i]) bad = i;
    n_chk++;
    if (bad == -1) n_pass++;
    else $display("FAIL %s bytes: got %0d bytes, need %0d, first bad index %0d",
                  nm, tx_q.size(), exp_q.size(), bad);
    if (!v.w) model_rd[v.p] = v.reply;
    check({nm, " rdata0"}, 80'(bus.rdata0), 80'(model_rd[0]));
    check({nm, " rdata1"}, 80'(bus.rdata1), 80'(model_rd[1]));
  endtask

  vec_t tbl[6];
  vec_t rv;
  logic [79:0] zero_vec;
  logic [3:0] dseq;
  logic [31:0] hdrs;
  int nd;

  initial begin
    bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
    bus.addr0 = 0; bus.addr1 = 0; bus.wdata0 = 0; bus.wdata1 = 0;
    bus.send_able = 1; bus.recv_able = 0; bus.recv_data = 0;
    prev_d0 = 0; prev_d1 = 0;
    model_rd[0] = '0; model_rd[1] = '0;

    //         p  w  addr          wdata         reply         from len pct drop hdr  lat
    tbl[0] = '{1'b0, 1'b1, 32'h00001000, 32'hDEADBEEF, 32'h0,        99, 0, 0, 0, 8'h80, 10};
    tbl[1] = '{1'b1, 1'b0, 32'h00000004, 32'h0,        32'h12345678, 99, 0, 0, 0, 8'h01, 10};
    tbl[2] = '{1'b0, 1'b1, 32'h00001000, 32'hDEADBEEF, 32'h0,        4,  3, 0, 0, 8'h80, 13};
    tbl[3] = '{1'b1, 1'b1, 32'hCAFE0010, 32'h01020304, 32'h0,        99, 0, 0, 1, 8'h81, 10};
    tbl[4] = '{1'b0, 1'b0, 32'h00000020, 32'h0,        32'hA5A55A5A, 7,  2, 0, 0, 8'h00, 12};
    tbl[5] = '{1'b0, 1'b0, 32'h00000040, 32'h0,        32'h11223344, 99, 0, 0, 1, 8'h00, 10};

    @(negedge clk);
    #1;
    zero_vec = {3'b0, bus.rdata0, bus.rdata1, bus.done0, bus.done1, bus.busy,
                bus.send_flag, bus.send_data, bus.recv_flag};
    check("reset outputs", zero_vec, 80'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle busy", 80'(bus.busy), 80'd0);

    for (int i = 0; i < 6; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

    // Stray RX byte while idle is popped and dropped before a read.
    popped_q.delete();
    rx_q.delete();
    rx_q.push_back(8'hAA);
    tick();
    tick();
    check("stray pop", (popped_q.size() == 1) ? 80'(popped_q[0]) : 80'hx, 80'hAA);
    rv = '{1'b1, 1'b0, 32'h00000100, 32'h0, 32'h0BADF00D, 99, 0, 0, 0, 8'h01, 10};
    run_txn(rv, "stray read");

    for (int k = 0; k < 20; k++) begin
      rv.p = $urandom; rv.w = $urandom; rv.addr = $urandom; rv.wdata = $urandom;
      rv.reply = $urandom; rv.st_from = 99; rv.st_len = 0;
      rv.stall_pct = ($urandom_range(1) == 1) ? 30 : 0;
      rv.drop = $urandom; rv.exp_hdr = {rv.w, 6'b0, rv.p};
      rv.exp_lat = (rv.stall_pct == 0) ? 10 : -1;
      run_txn(rv, $sformatf("rand%0d", k));
    end

    // Reset in the middle of a read that is starved of RX bytes.
    rx_q.delete();
    rx_q.push_back(8'h01);
    rx_q.push_back(8'h02);
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'h80;
    for (int c = 0; c < 8; c++) tick();
    bus.req0 = 1'b0;
    tick();
    tick();
    check("stalled busy", 80'(bus.busy), 80'd1);
    rst = 1'b1;
    #1;
    zero_vec = {3'b0, bus.rdata0, bus.rdata1, bus.done0, bus.done1, bus.busy,
                bus.send_flag, bus.send_data, bus.recv_flag};
    check("mid-read reset outputs", zero_vec, 80'd0);
    @(negedge clk);
    rst = 1'b0;
    model_rd[0] = '0; model_rd[1] = '0;
    rv = '{1'b0, 1'b0, 32'h00000080, 32'h0, 32'hCAFEBABE, 99, 0, 0, 0, 8'h00, 10};
    run_txn(rv, "post-reset read");

    // Both ports requesting continuously alternate, starting with port 0 after reset.
    do_reset();
    tx_q.delete();
    bus.we0 = 1'b1; bus.we1 = 1'b1; bus.addr0 = 32'h1; bus.addr1 = 32'h2;
    bus.req0 = 1'b1; bus.req1 = 1'b1; bus.send_able = 1'b1;
    nd = 0; dseq = 4'h0;
    for (int c = 0; c < 100 && nd < 4; c++) begin
      tick();
      if (d0 || d1) begin
        dseq = {dseq[2:0], d1};
        nd++;
      end
      if (nd == 4) begin bus.req0 = 1'b0; bus.req1 = 1'b0; end
    end
    tick();
    check("rr done count", 80'(nd), 80'd4);
    check("rr done order", 80'(dseq), 80'b0101);
    hdrs = (tx_q.size() >= 28) ? {tx_q[0], tx_q[9], tx_q[18], tx_q[27]} : 32'hx;
    check("rr headers", 80'(hdrs), 80'h80818081);
    check("rr total bytes", 80'(tx_q.size()), 80'd36);

    check("flag/done exclusivity", 80'(conflicts), 80'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
